// File: rtl/tile_config_loader_pkg.sv
// Shared types and field layout for the tile configuration loader.
// The 146-bit tile configuration is LE0, LE1, then the switchbox, LSB first.
package tile_cfg_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    COMMIT = 2'd2,
    PASS   = 2'd3
  } cfg_state_e;

  localparam int TILE_CONFIG_WIDTH = 146;

  localparam int LE0_LSB = 0;
  localparam int LE0_MSB = 16;
  localparam int LE1_LSB = 17;
  localparam int LE1_MSB = 33;
  localparam int SB_LSB  = 34;
  localparam int SB_MSB  = 145;

endpackage

// File: rtl/tile_config_loader_if.sv
// Beat-serial configuration stream: restart pulse plus valid/ready data beats.
// Used both for the upstream feed and for the daisy-chain output.
interface tile_config_loader_if #(
  parameter int SHIFT_WIDTH = 1
);
  logic                   start;
  logic [SHIFT_WIDTH-1:0] data;
  logic                   valid;
  logic                   ready;

  modport master (output start, output data, output valid, input ready);
  modport slave  (input start, input data, input valid, output ready);
endinterface

// File: rtl/tile_config_loader.sv
// Shifts a config frame into a shadow register, commits it atomically to config_out, then forwards later beats downstream.
// Optional even-parity trailer beat when TILE_CONFIG_PARITY_EN is defined.
module tile_config_loader
  import tile_cfg_pkg::*;
#(
  parameter int CONFIG_WIDTH = TILE_CONFIG_WIDTH,
  parameter int SHIFT_WIDTH  = 1
) (
  input  logic                    clock,
  input  logic                    nreset,
  tile_config_loader_if.slave     up,
  tile_config_loader_if.master    chain,
  output logic [CONFIG_WIDTH-1:0] config_out,
  output logic                    config_loaded,
  output logic                    cfg_busy,
  output logic                    cfg_error
);

  localparam int BEATS = CONFIG_WIDTH / SHIFT_WIDTH;
  localparam int CNT_W = $clog2(BEATS + 1);
  localparam logic [CNT_W-1:0] LAST_PAYLOAD = CNT_W'(BEATS - 1);

  if (CONFIG_WIDTH % SHIFT_WIDTH != 0) begin : g_bad_width
    $error("CONFIG_WIDTH must be a multiple of SHIFT_WIDTH");
  end

  cfg_state_e               state, state_nxt;
  logic [CONFIG_WIDTH-1:0]  shadow;
  logic [CNT_W-1:0]         cnt;
  logic                     chain_start_q;
  logic [SHIFT_WIDTH-1:0]   chain_data_q;
  logic                     chain_valid_q;
  logic                     accept;
  logic                     last_beat;
  logic                     commit_ok;

  assign up.ready = (state == SHIFT) ||
                    ((state == PASS) && (!chain_valid_q || chain.ready));
  // A beat coinciding with a restart belongs to no frame.
  assign accept   = up.valid && up.ready && !up.start;
  assign cfg_busy = (state == SHIFT) || (state == COMMIT);

  assign chain.start = chain_start_q;
  assign chain.data  = chain_data_q;
  assign chain.valid = chain_valid_q;

`ifdef TILE_CONFIG_PARITY_EN
  localparam logic [CNT_W-1:0] PARITY_BEAT = CNT_W'(BEATS);
  logic error_q;
  logic parity_beat;

  // The parity beat follows the payload; the counter parks at BEATS for it.
  assign parity_beat = (cnt == PARITY_BEAT);
  assign last_beat   = parity_beat;
  assign commit_ok   = (up.data[0] == ^shadow);
  assign cfg_error   = error_q;
`else
  assign last_beat = (cnt == LAST_PAYLOAD);
  assign commit_ok = 1'b1;
  assign cfg_error = 1'b0;
`endif

  always_ff @(posedge clock or negedge nreset) begin
    if (!nreset) state <= IDLE;
    else         state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:   state_nxt = IDLE;
      SHIFT:  if (accept && last_beat) state_nxt = commit_ok ? COMMIT : IDLE;
      COMMIT: state_nxt = PASS;
      PASS:   state_nxt = PASS;
      default: state_nxt = IDLE;
    endcase
    if (up.start) state_nxt = SHIFT;
  end

  always_ff @(posedge clock or negedge nreset) begin
    if (!nreset) begin
      config_out    <= '0;
      shadow        <= '0;
      cnt           <= '0;
      config_loaded <= 1'b0;
      chain_start_q <= 1'b0;
      chain_data_q  <= '0;
      chain_valid_q <= 1'b0;
`ifdef TILE_CONFIG_PARITY_EN
      error_q       <= 1'b0;
`endif
    end else begin
      chain_start_q <= up.start;
      if (up.start) begin
        cnt           <= '0;
        config_loaded <= 1'b0;
        chain_valid_q <= 1'b0;
`ifdef TILE_CONFIG_PARITY_EN
        error_q       <= 1'b0;
`endif
      end else begin
        case (state)
          SHIFT: begin
            if (accept) begin
`ifdef TILE_CONFIG_PARITY_EN
              if (parity_beat) begin
                if (!commit_ok) error_q <= 1'b1;
              end else begin
                shadow <= {up.data, shadow[CONFIG_WIDTH-1:SHIFT_WIDTH]};
                cnt    <= cnt + 1'b1;
              end
`else
              shadow <= {up.data, shadow[CONFIG_WIDTH-1:SHIFT_WIDTH]};
              cnt    <= cnt + 1'b1;
`endif
            end
          end
          COMMIT: begin
            config_out    <= shadow;
            config_loaded <= 1'b1;
          end
          PASS: begin
            if (accept) begin
              chain_data_q  <= up.data;
              chain_valid_q <= 1'b1;
            end else if (chain.ready) begin
              chain_valid_q <= 1'b0;
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_tile_config_loader.sv
// Directed bench for tile_config_loader: load, forward, backpressure, reset, atomic update, optional parity.
module tb_tile_config_loader;
  localparam int W = 146;
`ifdef TILE_CONFIG_PARITY_EN
  localparam int NB = W + 1;
`else
  localparam int NB = W;
`endif

  logic         clock;
  logic         nreset;
  logic [W-1:0] config_out;
  logic         config_loaded;
  logic         cfg_busy;
  logic         cfg_error;

  int checks = 0;
  int passed = 0;

  logic [W-1:0] pat;
  logic [W-1:0] ones;

  tile_config_loader_if #(.SHIFT_WIDTH(1)) up_if ();
  tile_config_loader_if #(.SHIFT_WIDTH(1)) chain_if ();

  tile_config_loader #(.CONFIG_WIDTH(W), .SHIFT_WIDTH(1)) dut (
    .clock         (clock),
    .nreset        (nreset),
    .up            (up_if.slave),
    .chain         (chain_if.master),
    .config_out    (config_out),
    .config_loaded (config_loaded),
    .cfg_busy      (cfg_busy),
    .cfg_error     (cfg_error)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  // Stimulus only: start pulse, NB beats, ends at the negedge in COMMIT.
  task automatic send_frame(input logic [W-1:0] v, input logic par);
    @(negedge clock);
    up_if.start = 1'b1;
    up_if.valid = 1'b0;
    for (int i = 0; i < NB; i++) begin
      @(negedge clock);
      up_if.start = 1'b0;
      up_if.valid = 1'b1;
      up_if.data  = (i < W) ? v[i] : par;
    end
    @(negedge clock);
    up_if.valid = 1'b0;
  endtask

  task automatic test_reset();
    nreset = 1'b0;
    up_if.start = 1'b0;
    up_if.valid = 1'b0;
    up_if.data = 1'b0;
    chain_if.ready = 1'b0;
    #12;
    checks++; if (config_out !== '0) $display("FAIL rst_config: got %h want 0", config_out); else passed++;
    checks++; if (config_loaded !== 1'b0) $display("FAIL rst_loaded: got %b want 0", config_loaded); else passed++;
    checks++; if (up_if.ready !== 1'b0) $display("FAIL rst_ready: got %b want 0", up_if.ready); else passed++;
    checks++; if (chain_if.valid !== 1'b0 || chain_if.start !== 1'b0 || chain_if.data !== 1'b0)
      $display("FAIL rst_chain: got v%b s%b d%b want 0", chain_if.valid, chain_if.start, chain_if.data); else passed++;
    checks++; if (cfg_busy !== 1'b0 || cfg_error !== 1'b0)
      $display("FAIL rst_flags: got busy %b err %b want 0 0", cfg_busy, cfg_error); else passed++;
    @(negedge clock);
    nreset = 1'b1;
    @(negedge clock);
    checks++; if (up_if.ready !== 1'b0) $display("FAIL idle_ready: got %b want 0", up_if.ready); else passed++;
  endtask

  task automatic test_load();
    int bad_ready;
    bad_ready = 0;
    up_if.start = 1'b1;
    up_if.valid = 1'b1;
    up_if.data  = 1'b1;
    for (int i = 0; i < NB; i++) begin
      @(negedge clock);
      up_if.start = 1'b0;
      if (up_if.ready !== 1'b1) bad_ready++;
      up_if.data = (i < W) ? pat[i] : ^pat;
    end
    checks++; if (bad_ready != 0) $display("FAIL load_ready_high: got %0d low cycles want 0", bad_ready); else passed++;
    @(negedge clock);
    up_if.valid = 1'b0;
    checks++; if (up_if.ready !== 1'b0) $display("FAIL load_commit_ready: got %b want 0", up_if.ready); else passed++;
    checks++; if (cfg_busy !== 1'b1) $display("FAIL load_commit_busy: got %b want 1", cfg_busy); else passed++;
    checks++; if (config_out !== '0) $display("FAIL load_early: got %h want 0", config_out); else passed++;
    @(negedge clock);
    checks++; if (config_out !== pat) $display("FAIL load_config: got %h want %h", config_out, pat); else passed++;
    checks++; if (config_out[16:0] !== 17'b01001001001001001)
      $display("FAIL load_le0: got %b want 01001001001001001", config_out[16:0]); else passed++;
    checks++; if (config_loaded !== 1'b1 || cfg_busy !== 1'b0)
      $display("FAIL load_flags: got loaded %b busy %b want 1 0", config_loaded, cfg_busy); else passed++;
  endtask

  task automatic test_forward();
    logic seq [0:9];
    seq = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
    chain_if.ready = 1'b1;
    for (int k = 0; k < 10; k++) begin
      checks++; if (up_if.ready !== 1'b1) $display("FAIL fwd_ready beat %0d: got %b want 1", k, up_if.ready); else passed++;
      if (k > 0) begin
        checks++; if (chain_if.valid !== 1'b1 || chain_if.data !== seq[k-1])
          $display("FAIL fwd_data beat %0d: got v%b d%b want v1 d%b", k - 1, chain_if.valid, chain_if.data, seq[k-1]);
        else passed++;
      end
      up_if.valid = 1'b1;
      up_if.data  = seq[k];
      @(negedge clock);
    end
    up_if.valid = 1'b0;
    checks++; if (chain_if.valid !== 1'b1 || chain_if.data !== seq[9])
      $display("FAIL fwd_last: got v%b d%b want v1 d%b", chain_if.valid, chain_if.data, seq[9]); else passed++;
    @(negedge clock);
    checks++; if (chain_if.valid !== 1'b0) $display("FAIL fwd_drain: got %b want 0", chain_if.valid); else passed++;
    checks++; if (config_out !== pat) $display("FAIL fwd_config: got %h want %h", config_out, pat); else passed++;
  endtask

  task automatic test_backpressure();
    chain_if.ready = 1'b0;
    up_if.valid = 1'b1;
    up_if.data  = 1'b1;
    @(negedge clock);
    up_if.data = 1'b0;
    for (int c = 0; c < 3; c++) begin
      checks++; if (up_if.ready !== 1'b0 || chain_if.valid !== 1'b1 || chain_if.data !== 1'b1)
        $display("FAIL bp_hold cycle %0d: got rdy%b v%b d%b want rdy0 v1 d1", c, up_if.ready, chain_if.valid, chain_if.data);
      else passed++;
      @(negedge clock);
    end
    chain_if.ready = 1'b1;
    #1;
    checks++; if (up_if.ready !== 1'b1) $display("FAIL bp_release_ready: got %b want 1", up_if.ready); else passed++;
    @(negedge clock);
    up_if.valid = 1'b0;
    checks++; if (chain_if.valid !== 1'b1 || chain_if.data !== 1'b0)
      $display("FAIL bp_second: got v%b d%b want v1 d0", chain_if.valid, chain_if.data); else passed++;
    @(negedge clock);
    checks++; if (chain_if.valid !== 1'b0) $display("FAIL bp_drain: got %b want 0", chain_if.valid); else passed++;
  endtask

  task automatic test_reset_mid_frame();
    @(negedge clock);
    up_if.start = 1'b1;
    for (int i = 0; i < 70; i++) begin
      @(negedge clock);
      up_if.start = 1'b0;
      up_if.valid = 1'b1;
      up_if.data  = 1'b1;
    end
    @(negedge clock);
    up_if.valid = 1'b0;
    checks++; if (cfg_busy !== 1'b1 || config_out !== pat)
      $display("FAIL mid_shift: got busy %b cfg %h want busy 1 cfg %h", cfg_busy, config_out, pat); else passed++;
    nreset = 1'b0;
    #1;
    checks++; if (config_out !== '0 || config_loaded !== 1'b0)
      $display("FAIL mid_reset: got cfg %h loaded %b want 0 0", config_out, config_loaded); else passed++;
    checks++; if (up_if.ready !== 1'b0 || cfg_busy !== 1'b0)
      $display("FAIL mid_reset_idle: got rdy %b busy %b want 0 0", up_if.ready, cfg_busy); else passed++;
    @(negedge clock);
    nreset = 1'b1;
    @(negedge clock);
    checks++; if (up_if.ready !== 1'b0 || cfg_busy !== 1'b0)
      $display("FAIL mid_after: got rdy %b busy %b want 0 0", up_if.ready, cfg_busy); else passed++;
  endtask

  task automatic test_atomic_update();
    int bad_hold;
    bad_hold = 0;
    send_frame(ones, 1'b0);
    @(negedge clock);
    checks++; if (config_out !== ones) $display("FAIL atom_ones: got %h want %h", config_out, ones); else passed++;
    checks++; if (chain_if.start !== 1'b0) $display("FAIL atom_cs_before: got %b want 0", chain_if.start); else passed++;
    up_if.start = 1'b1;
    for (int i = 0; i < NB; i++) begin
      @(negedge clock);
      if (i == 0) begin
        up_if.start = 1'b0;
        checks++; if (chain_if.start !== 1'b1) $display("FAIL atom_cs_pulse: got %b want 1", chain_if.start); else passed++;
      end
      if (i == 1) begin
        checks++; if (chain_if.start !== 1'b0) $display("FAIL atom_cs_end: got %b want 0", chain_if.start); else passed++;
      end
      if (config_out !== ones) bad_hold++;
      up_if.valid = 1'b1;
      up_if.data  = 1'b0;
    end
    @(negedge clock);
    up_if.valid = 1'b0;
    checks++; if (bad_hold != 0 || config_out !== ones)
      $display("FAIL atom_hold: got %0d partial cycles cfg %h want 0 cycles all ones", bad_hold, config_out); else passed++;
    @(negedge clock);
    checks++; if (config_out !== '0 || config_loaded !== 1'b1)
      $display("FAIL atom_commit: got cfg %h loaded %b want 0 1", config_out, config_loaded); else passed++;
  endtask

`ifdef TILE_CONFIG_PARITY_EN
  task automatic test_parity();
    send_frame(ones, 1'b1);
    checks++; if (cfg_error !== 1'b1) $display("FAIL par_err: got %b want 1", cfg_error); else passed++;
    checks++; if (config_out !== '0 || config_loaded !== 1'b0)
      $display("FAIL par_hold: got cfg %h loaded %b want 0 0", config_out, config_loaded); else passed++;
    checks++; if (cfg_busy !== 1'b0 || up_if.ready !== 1'b0)
      $display("FAIL par_idle: got busy %b rdy %b want 0 0", cfg_busy, up_if.ready); else passed++;
    send_frame(ones, 1'b0);
    @(negedge clock);
    checks++; if (config_out !== ones || config_loaded !== 1'b1 || cfg_error !== 1'b0)
      $display("FAIL par_ok: got cfg %h loaded %b err %b want ones 1 0", config_out, config_loaded, cfg_error); else passed++;
  endtask
`endif

  initial begin
    for (int i = 0; i < W; i++) pat[i] = (i % 3 == 0);
    ones = '1;
    test_reset();
    test_load();
    test_forward();
    test_backpressure();
    test_reset_mid_frame();
    test_atomic_update();
`ifdef TILE_CONFIG_PARITY_EN
    test_parity();
`endif
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/tile_config_loader.md
Name: tile_config_loader

Overview:
- Configuration loader that sits directly upstream of a logic tile.
- Accepts a beat-serial configuration stream, assembles it in a shadow register, then commits it atomically onto the tile's 146-bit configuration bus.
- After its own frame is committed, forwards all further beats to the next tile's loader, forming a daisy chain across the fabric.
- Reset drives an all-zero configuration, so the tile is inert until loaded.

Parameters:
- CONFIG_WIDTH, 146, width of the tile configuration bus (LE0 17 + LE1 17 + switchbox 112).
- SHIFT_WIDTH, 1, bits per stream beat; CONFIG_WIDTH must be an integer multiple of it (elaboration error otherwise).
- BEATS, CONFIG_WIDTH/SHIFT_WIDTH, derived local constant; payload beats per frame.

Ports:
- clock  in  1  single clock, rising edge.
- nreset  in  1  asynchronous, active-low reset.
- cfg_start  in  1  one-cycle pulse: begin a new frame, from any state.
- cfg_data  in  SHIFT_WIDTH  stream beat.
- cfg_valid  in  1  beat valid.
- cfg_ready  out  1  beat accepted when cfg_valid && cfg_ready.
- cfg_chain_start  out  1  cfg_start delayed by one register.
- cfg_chain_data  out  SHIFT_WIDTH  forwarded beat to the downstream loader.
- cfg_chain_valid  out  1  forwarded beat valid.
- cfg_chain_ready  in  1  downstream ready.
- config_out  out  CONFIG_WIDTH  configuration to the tile.
- config_loaded  out  1  config_out holds a committed frame.
- cfg_busy  out  1  high in SHIFT or COMMIT.
- cfg_error  out  1  parity failure, sticky; constant 0 without the optional feature.

Behaviour:
- Reset (async, nreset low): state IDLE; config_out, shadow, beat counter, cfg_chain_data, cfg_chain_valid, cfg_chain_start, config_loaded, cfg_error all 0. Reset mid-frame discards the partial frame and zeroes config_out.
- States: IDLE, SHIFT, COMMIT, PASS.
- IDLE:
  - cfg_ready=0.
  - cfg_start → SHIFT.
- cfg_start in any state:
  - Next state SHIFT; counter cleared; config_loaded and cfg_error cleared.
  - cfg_chain_valid cleared, dropping any pending forwarded beat.
  - config_out retains its previous value.
  - A beat presented in the same cycle as cfg_start is ignored.
- SHIFT:
  - cfg_ready=1.
  - On each accepted beat: shadow <= {cfg_data, shadow[CONFIG_WIDTH-1:SHIFT_WIDTH]}, counter+1. The first beat lands in config bits [SHIFT_WIDTH-1:0].
  - When beat BEATS-1 is accepted → COMMIT (or → PARITY check beat, see Optional Feature).
- COMMIT (exactly one cycle):
  - cfg_ready=0.
  - At the closing edge: config_out <= shadow, config_loaded <= 1, → PASS.
  - config_out therefore changes two edges after the last payload beat is accepted.
- PASS:
  - cfg_ready = !cfg_chain_valid || cfg_chain_ready.
  - Accepted beat → cfg_chain_data, cfg_chain_valid=1 at the next edge (1-cycle latency).
  - cfg_chain_valid clears when the beat is taken by the downstream loader and no new beat is accepted.
  - Full throughput while cfg_chain_ready is held high.
- cfg_chain_start: registered copy of cfg_start, so downstream loaders restart one cycle later.
- config_out never shows a partial frame. Updates happen only at COMMIT or reset.
- Counter width: clog2(BEATS+1). It never wraps, because leaving SHIFT stops it.

Optional Feature:
- Macro: TILE_CONFIG_PARITY_EN.
- Defined:
  - After the BEATS payload beats, SHIFT accepts one extra parity beat; only cfg_data[0] is checked.
  - Expected value: XOR of all CONFIG_WIDTH payload bits (even parity).
  - Match → COMMIT as normal.
  - Mismatch → config_out unchanged, config_loaded=0, cfg_error=1 (sticky until cfg_start or reset), → IDLE. Nothing is forwarded downstream.
- Undefined: no parity beat; cfg_error tied 0; SHIFT → COMMIT directly.

Decomposition:
- Package tile_cfg_pkg:
  - State enum (IDLE, SHIFT, COMMIT, PASS).
  - TILE_CONFIG_WIDTH=146.
  - Field offsets: LE0 [16:0], LE1 [33:17], switchbox [145:34].
- Single module; no sub-module warranted.
- The tile wrapper instantiates this loader and connects config_out to the tile's config_in.

Test Plan:
- Reset, then 146 beats of pattern bit i = i%3==0, cfg_valid held 1 → cfg_ready=1 for exactly 146 cycles, then 0 for one cycle. config_out equals the pattern exactly two edges after the last beat, with config_loaded=1. config_out[16:0] equals the first 17 beats.
- Continue sending 10 beats 1,0,1,1,0,0,1,0,1,1 with cfg_chain_ready=1 → the same sequence appears on cfg_chain_data one cycle later; config_out unchanged.
- In PASS, hold cfg_chain_ready=0 → one beat is forwarded, then cfg_ready=0 until the downstream loader accepts. No beat is lost or duplicated.
- After a loaded frame, assert cfg_start, send 70 beats, then pulse nreset → config_out=0, config_loaded=0, state IDLE, cfg_ready=0.
- After a loaded frame of all 1s, assert cfg_start and load all 0s → config_out stays all 1s through SHIFT. It becomes 0 only after COMMIT; cfg_chain_start pulses one cycle after cfg_start.
- With TILE_CONFIG_PARITY_EN: send all-ones payload (146 ones, parity 0) plus parity beat 1 → cfg_error=1, config_out unchanged, state IDLE. Repeat with parity beat 0 → commit occurs and cfg_error=0.
